// File: rtl/hls_deadlock_pkg.sv
// Shared types, default widths and helpers for the deadlock report unit.
//   state_e   : report FSM encoding
//   sat_inc() : saturating increment on a value no wider than 32 bits
package hls_deadlock_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StArm    = 2'd1,
    StReport = 2'd2,
    StHold   = 2'd3
  } state_e;

  localparam int unsigned NIdleDefault         = 9;
  localparam int unsigned NBlockDefault        = 4;
  localparam int unsigned NAxisDefault         = 3;
  localparam int unsigned ConfirmCyclesDefault = 16;

  // Callers zero-extend into 32 bits and truncate the result back.
  function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max_val);
    return (val >= max_val) ? val : val + 32'd1;
  endfunction

endpackage

// File: rtl/hls_deadlock_persist_filter.sv
// Persistence filter for the monitor's block flag.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   start_i      : block first seen while idle; the counter loads 1
//   arm_i        : parent FSM is in the ARM state
//   block_i      : block flag from the monitor
//   confirm_o    : block held for CONFIRM_CYCLES consecutive samples (pulse)
//   glitch_o     : block dropped before confirmation (pulse)
module hls_deadlock_persist_filter
  import hls_deadlock_pkg::*;
#(
  parameter int unsigned CONFIRM_CYCLES = ConfirmCyclesDefault
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic start_i,
  input  logic arm_i,
  input  logic block_i,
  output logic confirm_o,
  output logic glitch_o
);

  // CONFIRM_CYCLES >= 2, so CONFIRM_CYCLES-1 always fits in clog2 bits.
  localparam int unsigned     CntW    = $clog2(CONFIRM_CYCLES);
  localparam logic [CntW-1:0] CntLast = CntW'(CONFIRM_CYCLES - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d     = cnt_q;
    confirm_o = 1'b0;
    glitch_o  = 1'b0;
    if (start_i) begin
      // The sample that leaves IDLE already counts as the first one.
      cnt_d = CntW'(1);
    end else if (arm_i) begin
      if (!block_i) begin
        cnt_d    = '0;
        glitch_o = 1'b1;
      end else if (cnt_q == CntLast) begin
        cnt_d     = '0;
        confirm_o = 1'b1;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/hls_deadlock_report_unit.sv
// Confirms persistent dataflow deadlocks and emits one snapshot report beat.
//   clock_i, reset_i          : clock, asynchronous active-high reset
//   block_i                   : registered deadlock flag from the monitor
//   inst_idle_sigs_i          : per-instance idle flags
//   inst_block_sigs_i         : per-instance channel-block flags
//   axis_block_sigs_i         : AXIS stall flags
//   clear_i                   : releases the sticky deadlock while holding
//   report_valid_o/ready_i    : report beat handshake
//   report_idle/block/axis_o  : snapshot taken on the first block cycle
//   report_ts_o               : timestamp of the first block cycle
//   deadlock_o                : sticky confirmed-deadlock flag
//   deadlock_total_o          : confirmed deadlocks, saturating
//   glitch_total_o            : filtered transient episodes, saturating
module hls_deadlock_report_unit
  import hls_deadlock_pkg::*;
#(
  parameter int unsigned N_IDLE         = NIdleDefault,
  parameter int unsigned N_BLOCK        = NBlockDefault,
  parameter int unsigned N_AXIS         = NAxisDefault,
  parameter int unsigned CONFIRM_CYCLES = ConfirmCyclesDefault,
  parameter int unsigned TS_W           = 32,
  parameter int unsigned CNT_W          = 8
) (
  input  logic               clock_i,
  input  logic               reset_i,
  input  logic               block_i,
  input  logic [N_IDLE-1:0]  inst_idle_sigs_i,
  input  logic [N_BLOCK-1:0] inst_block_sigs_i,
  input  logic [N_AXIS-1:0]  axis_block_sigs_i,
  input  logic               clear_i,
  output logic               report_valid_o,
  input  logic               report_ready_i,
  output logic [N_IDLE-1:0]  report_idle_o,
  output logic [N_BLOCK-1:0] report_block_o,
  output logic [N_AXIS-1:0]  report_axis_o,
  output logic [TS_W-1:0]    report_ts_o,
  output logic               deadlock_o,
  output logic [CNT_W-1:0]   deadlock_total_o,
  output logic [CNT_W-1:0]   glitch_total_o
);

  localparam logic [CNT_W-1:0] CntMax = '1;

  state_e             state_q, state_d;
  logic [TS_W-1:0]    ts_q, ts_d;
  logic [N_IDLE-1:0]  idle_q, idle_d;
  logic [N_BLOCK-1:0] blk_q, blk_d;
  logic [N_AXIS-1:0]  axis_q, axis_d;
  logic [TS_W-1:0]    rts_q, rts_d;
  logic [CNT_W-1:0]   dl_total_q, dl_total_d;
  logic [CNT_W-1:0]   gl_total_q, gl_total_d;
  logic               valid_q, valid_d;
  logic               deadlock_q, deadlock_d;

  logic start, arm, confirm, glitch;

  assign start = (state_q == StIdle) && block_i;
  assign arm   = (state_q == StArm);

  hls_deadlock_persist_filter #(
    .CONFIRM_CYCLES (CONFIRM_CYCLES)
  ) u_filter (
    .clk_i     (clock_i),
    .rst_i     (reset_i),
    .start_i   (start),
    .arm_i     (arm),
    .block_i   (block_i),
    .confirm_o (confirm),
    .glitch_o  (glitch)
  );

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (block_i) state_d = StArm;
      end
      StArm: begin
        if (glitch) begin
          state_d = StIdle;
        end else if (confirm) begin
          state_d = StReport;
        end
      end
      // block/clear are ignored here so an issued report is never lost.
      StReport: begin
        if (report_ready_i) state_d = StHold;
      end
      // A block sampled together with clear does not open a new episode.
      StHold: begin
        if (clear_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Output and datapath next-state logic.
  always_comb begin
    ts_d       = ts_q + TS_W'(1);
    idle_d     = idle_q;
    blk_d      = blk_q;
    axis_d     = axis_q;
    rts_d      = rts_q;
    dl_total_d = dl_total_q;
    gl_total_d = gl_total_q;
    valid_d    = (state_d == StReport);
    deadlock_d = (state_d == StReport) || (state_d == StHold);

    if (start) begin
      idle_d = inst_idle_sigs_i;
      blk_d  = inst_block_sigs_i;
      axis_d = axis_block_sigs_i;
      rts_d  = ts_q;
    end
    if (confirm) begin
      dl_total_d = CNT_W'(sat_inc(32'(dl_total_q), 32'(CntMax)));
    end
    if (glitch) begin
      gl_total_d = CNT_W'(sat_inc(32'(gl_total_q), 32'(CntMax)));
    end
  end

  // State registers.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= StIdle;
      ts_q       <= '0;
      idle_q     <= '0;
      blk_q      <= '0;
      axis_q     <= '0;
      rts_q      <= '0;
      dl_total_q <= '0;
      gl_total_q <= '0;
      valid_q    <= 1'b0;
      deadlock_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ts_q       <= ts_d;
      idle_q     <= idle_d;
      blk_q      <= blk_d;
      axis_q     <= axis_d;
      rts_q      <= rts_d;
      dl_total_q <= dl_total_d;
      gl_total_q <= gl_total_d;
      valid_q    <= valid_d;
      deadlock_q <= deadlock_d;
    end
  end

  assign report_valid_o   = valid_q;
  assign report_idle_o    = idle_q;
  assign report_block_o   = blk_q;
  assign report_axis_o    = axis_q;
  assign report_ts_o      = rts_q;
  assign deadlock_o       = deadlock_q;
  assign deadlock_total_o = dl_total_q;
  assign glitch_total_o   = gl_total_q;

endmodule

// File: tb/tb_hls_deadlock_report_unit.sv
module tb_hls_deadlock_report_unit;

  localparam int Confirm = 16;

  logic        clock = 1'b0;
  logic        reset;
  logic        block, clear, ready;
  logic [8:0]  idle_s;
  logic [3:0]  blk_s;
  logic [2:0]  axis_s;
  logic        valid, deadlock;
  logic [8:0]  r_idle;
  logic [3:0]  r_blk;
  logic [2:0]  r_axis;
  logic [31:0] r_ts;
  logic [7:0]  dl_total, gl_total;

  // Second instance with a narrow timestamp to exercise wrap-around.
  logic        block2, clear2, ready2, valid2, deadlock2;
  logic [8:0]  r_idle2;
  logic [3:0]  r_blk2;
  logic [2:0]  r_axis2;
  logic [7:0]  r_ts2, dl_total2, gl_total2;

  always #5 clock = ~clock;

  hls_deadlock_report_unit dut (
    .clock_i           (clock),
    .reset_i           (reset),
    .block_i           (block),
    .inst_idle_sigs_i  (idle_s),
    .inst_block_sigs_i (blk_s),
    .axis_block_sigs_i (axis_s),
    .clear_i           (clear),
    .report_valid_o    (valid),
    .report_ready_i    (ready),
    .report_idle_o     (r_idle),
    .report_block_o    (r_blk),
    .report_axis_o     (r_axis),
    .report_ts_o       (r_ts),
    .deadlock_o        (deadlock),
    .deadlock_total_o  (dl_total),
    .glitch_total_o    (gl_total)
  );

  hls_deadlock_report_unit #(
    .CONFIRM_CYCLES (2),
    .TS_W           (8)
  ) dut2 (
    .clock_i           (clock),
    .reset_i           (reset),
    .block_i           (block2),
    .inst_idle_sigs_i  (idle_s),
    .inst_block_sigs_i (blk_s),
    .axis_block_sigs_i (axis_s),
    .clear_i           (clear2),
    .report_valid_o    (valid2),
    .report_ready_i    (ready2),
    .report_idle_o     (r_idle2),
    .report_block_o    (r_blk2),
    .report_axis_o     (r_axis2),
    .report_ts_o       (r_ts2),
    .deadlock_o        (deadlock2),
    .deadlock_total_o  (dl_total2),
    .glitch_total_o    (gl_total2)
  );

  // Reference timestamp: cycles since reset release.
  logic [31:0] m_ts;
  always @(posedge clock or posedge reset) begin
    if (reset) m_ts <= '0;
    else       m_ts <= m_ts + 32'd1;
  end

  typedef struct {
    logic [31:0] ts;
    logic [8:0]  idle;
    logic [3:0]  blk;
    logic [2:0]  axis;
  } rep_t;

  typedef struct {
    int         len;
    logic [8:0] idle;
    logic [3:0] blk;
    logic [2:0] axis;
    int         ready_dly;
    logic       exp_rep;
    int         exp_dl;
    int         exp_gl;
  } vec_t;

  rep_t sb[$];
  vec_t vecs[5];
  int   checks = 0;
  int   errors = 0;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] pack(input rep_t r);
    return {16'd0, r.ts, r.idle, r.blk, r.axis};
  endfunction

  function automatic logic [63:0] dut_payload();
    return {16'd0, r_ts, r_idle, r_blk, r_axis};
  endfunction

  initial begin
    rep_t r;
    vec_t v;
    int   guard;

    vecs[0] = '{16, 9'h1F0, 4'h3, 3'b001, 0,  1'b1, 1, 0};
    vecs[1] = '{15, 9'h0AA, 4'h5, 3'b010, 0,  1'b0, 1, 1};
    vecs[2] = '{1,  9'h155, 4'hA, 3'b100, 0,  1'b0, 1, 2};
    vecs[3] = '{20, 9'h001, 4'h9, 3'b011, 3,  1'b1, 2, 2};
    vecs[4] = '{16, 9'h0F0, 4'hC, 3'b110, 20, 1'b1, 3, 2};

    reset = 1'b1;
    block = 0; clear = 0; ready = 0;
    block2 = 0; clear2 = 0; ready2 = 0;
    idle_s = '0; blk_s = '0; axis_s = '0;
    #12;
    chk("rst_valid", valid, 0);
    chk("rst_deadlock", deadlock, 0);
    chk("rst_dl_total", dl_total, 0);
    chk("rst_gl_total", gl_total, 0);
    chk("rst_payload", dut_payload(), 0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 5; i++) begin
      v = vecs[i];
      if (i == 0) begin
        guard = 0;
        while (m_ts != 32'd100 && guard < 1000) begin
          tick();
          guard++;
        end
        chk("wait_ts100", m_ts, 100);
      end
      block  = 1'b1;
      idle_s = v.idle;
      blk_s  = v.blk;
      axis_s = v.axis;
      if (v.exp_rep) begin
        r.ts = m_ts; r.idle = v.idle; r.blk = v.blk; r.axis = v.axis;
        sb.push_back(r);
      end
      for (int k = 0; k < v.len; k++) begin
        tick();
        if (k == 0) begin
          idle_s = 9'h1FF; blk_s = ~v.blk; axis_s = ~v.axis;
        end
        if (k == Confirm - 2) chk("pre_valid", valid, 0);
        if (k == Confirm - 1) chk("latency_valid", valid, 1);
      end
      block = 1'b0;
      if (i == 0) chk("ts_100", r_ts, 100);

      if (v.exp_rep) begin
        chk("report_deadlock", deadlock, 1);
        for (int d = 0; d < v.ready_dly; d++) begin
          clear = (d % 2 == 0);
          block = (d % 3 == 0);
          tick();
          chk("stall_valid", valid, 1);
          if (sb.size() != 0) chk("stall_payload", dut_payload(), pack(sb[0]));
        end
        clear = 0;
        block = 0;
        ready = 1;
        chk("hs_valid", valid, 1);
        if (sb.size() == 0) begin
          chk("sb_nonempty", 0, 1);
        end else begin
          r = sb.pop_front();
          chk("hs_payload", dut_payload(), pack(r));
        end
        tick();
        ready = 0;
        chk("valid_drop", valid, 0);
        chk("hold_deadlock", deadlock, 1);
        chk("hold_payload", dut_payload(), pack(r));
        clear = 1;
        block = 1;
        tick();
        clear = 0;
        block = 0;
        chk("clear_deadlock", deadlock, 0);
        tick();
        tick();
        chk("no_new_episode", gl_total, v.exp_gl);
        chk("idle_valid", valid, 0);
      end else begin
        tick();
        chk("glitch_valid", valid, 0);
        chk("glitch_deadlock", deadlock, 0);
        tick();
        chk("glitch_idle_valid", valid, 0);
      end
      chk("dl_total", dl_total, v.exp_dl);
      chk("gl_total", gl_total, v.exp_gl);
    end

    // Asynchronous reset while a report is pending.
    block = 1;
    idle_s = 9'h0FF;
    r.ts = m_ts; r.idle = idle_s; r.blk = blk_s; r.axis = axis_s;
    sb.push_back(r);
    for (int k = 0; k < Confirm; k++) tick();
    block = 0;
    chk("pend_valid", valid, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("async_valid", valid, 0);
    chk("async_deadlock", deadlock, 0);
    chk("async_dl_total", dl_total, 0);
    chk("async_gl_total", gl_total, 0);
    sb.delete();
    tick();
    reset = 1'b0;
    tick();
    chk("post_rst_valid", valid, 0);

    // Glitch counter saturation.
    for (int e = 0; e < 300; e++) begin
      block = 1;
      tick();
      block = 0;
      tick();
    end
    chk("gl_saturate", gl_total, 255);
    chk("sat_dl_total", dl_total, 0);
    chk("sat_deadlock", deadlock, 0);

    // Timestamp wrap on the narrow instance.
    guard = 0;
    while (m_ts[7:0] != 8'hFF && guard < 600) begin
      tick();
      guard++;
    end
    chk("wait_ts_ff", m_ts[7:0], 8'hFF);
    tick();
    block2 = 1;
    tick();
    chk("wrap_pre_valid", valid2, 0);
    tick();
    block2 = 0;
    chk("wrap_valid", valid2, 1);
    chk("wrap_ts", r_ts2, 0);
    chk("wrap_dl_total", dl_total2, 1);
    ready2 = 1;
    tick();
    ready2 = 0;
    chk("wrap_hold_valid", valid2, 0);
    clear2 = 1;
    tick();
    clear2 = 0;
    chk("wrap_clear", deadlock2, 0);

    chk("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hls_deadlock_report_unit.md
Name: hls_deadlock_report_unit

Overview:
- Sits directly downstream of the dataflow deadlock monitor; consumes its registered `block` flag plus the raw idle/block vectors.
- Filters transient `block` pulses by requiring persistence for CONFIRM_CYCLES consecutive cycles.
- On confirmation, snapshots which processes/AXIS channels were stalled, with a cycle timestamp, and presents one report beat on a valid/ready interface.
- Holds a sticky deadlock flag until software/debug logic clears it.

Parameters:
- N_IDLE, 9, width of inst_idle_sigs
- N_BLOCK, 4, width of inst_block_sigs
- N_AXIS, 3, width of axis_block_sigs
- CONFIRM_CYCLES, 16, consecutive cycles `block` must be high to confirm; legal range >=2
- TS_W, 32, timestamp counter width
- CNT_W, 8, width of saturating event counters

Ports:
- clock  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- block  in  1  registered deadlock indication from monitor
- inst_idle_sigs  in  N_IDLE  per-instance idle flags
- inst_block_sigs  in  N_BLOCK  per-instance channel-block flags
- axis_block_sigs  in  N_AXIS  AXIS stall flags
- clear  in  1  acknowledge; releases sticky deadlock (HOLD state only)
- report_valid  out  1  report beat available
- report_ready  in  1  consumer accepts report
- report_idle  out  N_IDLE  snapshot of inst_idle_sigs
- report_block  out  N_BLOCK  snapshot of inst_block_sigs
- report_axis  out  N_AXIS  snapshot of axis_block_sigs
- report_ts  out  TS_W  timestamp of first `block` cycle
- deadlock  out  1  sticky confirmed-deadlock flag
- deadlock_total  out  CNT_W  confirmed deadlocks, saturating
- glitch_total  out  CNT_W  filtered transient episodes, saturating

Behaviour:
- Reset, asynchronous: state=IDLE; ts, persist count, snapshots, report_ts, both totals = 0; report_valid=0, deadlock=0. Reset asserted mid-report drops the pending beat.
- ts: free-running, +1 every cycle, wraps 2^TS_W-1 -> 0.
- FSM states: IDLE, ARM, REPORT, HOLD.
- IDLE: block=1 -> ARM; cnt<=1; capture snapshots of all three vectors and report_ts<=ts, same edge.
- ARM, block=0: -> IDLE; cnt<=0; glitch_total += 1, saturating at 2^CNT_W-1.
- ARM, block=1, cnt<CONFIRM_CYCLES-1: cnt += 1; snapshots not refreshed.
- ARM, block=1, cnt==CONFIRM_CYCLES-1: -> REPORT; deadlock<=1; deadlock_total += 1, saturating.
- Latency: report_valid rises one cycle after the CONFIRM_CYCLES-th consecutive sampled `block`=1.
- REPORT: report_valid=1; payload stable until accepted. report_ready=1 -> HOLD, report_valid<=0. `block` and `clear` are ignored; a report is never dropped.
- HOLD: deadlock=1; payload outputs keep the last snapshot; clear=1 -> IDLE, deadlock<=0.
- HOLD, clear=1 and block=1 same cycle: go to IDLE only. A new episode starts on a later cycle where block=1 is sampled in IDLE.
- report_* outputs are registered and change only on ARM entry.
- deadlock is a registered output, asserted exactly while state is REPORT or HOLD.

Decomposition:
- Shared package hls_deadlock_pkg holds:
  - state enum: IDLE=2'd0, ARM=2'd1, REPORT=2'd2, HOLD=2'd3
  - default widths N_IDLE/N_BLOCK/N_AXIS
  - CONFIRM_CYCLES default
  - saturating-increment function
- One natural sub-module: hls_deadlock_persist_filter.
  - Holds the ARM counter.
  - Outputs `confirm` and `glitch` pulses.
  - Parent keeps the FSM, snapshot registers and handshake.

Test Plan:
- Block high 16 cycles from ts=100, vectors idle=9'h1F0, blk=4'h3, axis=3'b001 -> report_valid rises after the 16th sampled cycle. Payload: report_ts=100, idle=9'h1F0, blk=4'h3, axis=3'b001. deadlock=1, deadlock_total=1.
- Block high 15 cycles then low -> no report_valid; glitch_total=1, deadlock stays 0, state back to IDLE.
- Confirmed report with report_ready held low 20 cycles, clear pulsed -> report_valid and payload stay constant. Raise ready -> valid drops next cycle, HOLD. Clear -> deadlock=0.
- Vectors change while in ARM (idle 9'h001 -> 9'h1FF) -> report_idle still shows 9'h001.
- Reset asserted asynchronously while report_valid=1 -> report_valid, deadlock and totals are 0 immediately, before any clock edge.
- 300 glitch episodes -> glitch_total saturates at 255. ts at 32'hFFFFFFFF wraps to 0 on the next cycle.
